// File: rtl/mm_mem_responder.sv
// mm_mem_responder
// Memory-mapped responder for the picorv32 native memory interface that hosts
// a sequenced matrix-row multiply engine (C = A x B, one MAC per cycle).
//
// Ports:
//   clk        system clock, all state updates on the rising edge
//   reset      synchronous active-high reset
//   mem_valid  core request valid
//   mem_instr  instruction fetch flag (answered like a read)
//   mem_addr   byte address, bits [1:0] ignored
//   mem_wdata  write data
//   mem_wstrb  byte write enables, zero means read
//   mem_ready  one-cycle acknowledge
//   mem_rdata  read data, zero whenever mem_ready is low
//   hit        combinational: request valid and inside the 4 KiB window
//   irq        one-cycle pulse when a computation completes
//
// Register map (offsets from BASE_ADDR):
//   0x000          CTRL  write bit0=start, bit1=clear done; read bit0=busy, bit1=done
//   0x100+4i       A[i]
//   0x400+4(i*H+j) B[i][j]
//   0x800+8j       C[j][31:0], 0x804+8j C[j][63:32] (read-only)
module mm_mem_responder #(
  parameter logic [31:0] BASE_ADDR    = 32'h0200_0000,
  parameter int          CHUNK_WIDTH  = 8,
  parameter int          CHUNK_HEIGHT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        hit,
  output logic        irq
);

  localparam int W  = CHUNK_WIDTH;
  localparam int H  = CHUNK_HEIGHT;
  localparam int AW = (W > 1) ? $clog2(W) : 1;
  localparam int HW = (H > 1) ? $clog2(H) : 1;
  localparam int BW = (W * H > 1) ? $clog2(W * H) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_e;

  state_e        state_q;
  logic [AW-1:0] iCnt_q;
  logic [HW-1:0] jCnt_q;
  logic [63:0]   acc_q;
  logic          done_q;
  logic          irq_q;
  logic          ready_q;
  logic [31:0]   rdata_q;
  logic [31:0]   aMem_q [W];
  logic [31:0]   bMem_q [W*H];
  logic [63:0]   cMem_q [H];

  logic          busy;
  logic          accept;
  logic          isWrite;
  logic          isCtrl, isA, isB, isC;
  int            wordIdx;
  logic [AW-1:0] aIdx;
  logic [BW-1:0] bIdx;
  logic [HW-1:0] cIdx;
  logic [BW-1:0] bRunIdx;
  logic [31:0]   aOp, bOp;
  logic [63:0]   aExt, bExt;
  logic [63:0]   product_d;
  logic [63:0]   sum_d;
  logic [31:0]   rdata_d;
  logic          startReq;
  logic          clearReq;
  logic          unusedBits;

  assign unusedBits = ^{mem_instr, mem_addr[1:0]};

  assign hit     = mem_valid && (mem_addr[31:12] == BASE_ADDR[31:12]);
  assign busy    = (state_q != IDLE);
  // A second request cannot be accepted in the acknowledge cycle, which
  // guarantees an idle cycle between back-to-back acknowledges.
  assign accept  = hit && !ready_q;
  assign isWrite = (mem_wstrb != 4'b0000);

  assign mem_ready = ready_q;
  assign mem_rdata = rdata_q;
  assign irq       = irq_q;

  // Word-granular decode of the in-window offset into the four regions.
  always_comb begin
    wordIdx = int'(mem_addr[11:2]);
    isCtrl  = (wordIdx == 0);
    isA     = (wordIdx >= 64)  && (wordIdx < 64 + W);
    isB     = (wordIdx >= 256) && (wordIdx < 256 + W * H);
    isC     = (wordIdx >= 512) && (wordIdx < 512 + 2 * H);
    aIdx    = AW'(wordIdx - 64);
    bIdx    = BW'(wordIdx - 256);
    cIdx    = HW'((wordIdx - 512) / 2);
  end

  // Multiply-accumulate datapath. Operands are sign-extended so the low 64
  // bits of the product equal the signed 32x32 product.
  always_comb begin
    bRunIdx   = BW'(int'(iCnt_q) * H + int'(jCnt_q));
    aOp       = aMem_q[iCnt_q];
    bOp       = bMem_q[bRunIdx];
    aExt      = {{32{aOp[31]}}, aOp};
    bExt      = {{32{bOp[31]}}, bOp};
    product_d = aExt * bExt;
    sum_d     = acc_q + product_d;
  end

  // Read mux; unmapped offsets read as zero.
  always_comb begin
    rdata_d = '0;
    if (isCtrl) begin
      rdata_d = {30'b0, done_q, busy};
    end else if (isA) begin
      rdata_d = aMem_q[aIdx];
    end else if (isB) begin
      rdata_d = bMem_q[bIdx];
    end else if (isC) begin
      rdata_d = mem_addr[2] ? cMem_q[cIdx][63:32] : cMem_q[cIdx][31:0];
    end
  end

  assign startReq = accept && isWrite && isCtrl && mem_wdata[0] && !busy;
  assign clearReq = accept && isWrite && isCtrl && mem_wdata[1];

  // Bus responder, compute FSM and storage share one sequential block so the
  // priority between them is explicit: the FSM updates first, then a W1C
  // clear (unless a start was accepted), then operand writes when idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      iCnt_q  <= '0;
      jCnt_q  <= '0;
      acc_q   <= '0;
      done_q  <= 1'b0;
      irq_q   <= 1'b0;
      ready_q <= 1'b0;
      rdata_q <= '0;
      for (int k = 0; k < W; k++)     aMem_q[k] <= '0;
      for (int k = 0; k < W * H; k++) bMem_q[k] <= '0;
      for (int k = 0; k < H; k++)     cMem_q[k] <= '0;
    end else begin
      irq_q   <= 1'b0;
      ready_q <= accept;
      rdata_q <= accept ? rdata_d : 32'h0;

      case (state_q)
        IDLE: begin
          if (startReq) begin
            state_q <= RUN;
            done_q  <= 1'b0;
            iCnt_q  <= '0;
            jCnt_q  <= '0;
            acc_q   <= '0;
          end
        end
        RUN: begin
          if (iCnt_q == AW'(W - 1)) begin
            cMem_q[jCnt_q] <= sum_d;
            acc_q          <= '0;
            iCnt_q         <= '0;
            if (jCnt_q == HW'(H - 1)) begin
              jCnt_q  <= '0;
              state_q <= FIN;
              irq_q   <= 1'b1;
            end else begin
              jCnt_q <= jCnt_q + HW'(1);
            end
          end else begin
            acc_q  <= sum_d;
            iCnt_q <= iCnt_q + AW'(1);
          end
        end
        FIN: begin
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase

      if (clearReq && !startReq) begin
        done_q <= 1'b0;
      end

      if (accept && isWrite && !busy) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_wstrb[b]) begin
            if (isA) aMem_q[aIdx][8*b +: 8] <= mem_wdata[8*b +: 8];
            if (isB) bMem_q[bIdx][8*b +: 8] <= mem_wdata[8*b +: 8];
          end
        end
      end
    end
  end

endmodule
